// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRsp  = 2'd2,
    StDone = 2'd3
  } dmem_state_e;

  localparam int unsigned DmemTimeout = 255;
  localparam int unsigned DmemToCntW  = 8;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Transaction watchdog for dmem_bridge; compiled only when DMEM_TIMEOUT_EN is defined.
`ifdef DMEM_TIMEOUT_EN
module dmem_timeout_cnt #(
  parameter int unsigned MAX_CYCLES = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the last allowed REQ/RSP cycle, so the FSM enters DONE right after it.
  assign expire = enable && (cnt_q == CNT_W'(MAX_CYCLES - 1));

endmodule
`endif

// File: rtl/dmem_bridge.sv
// MEM-stage RAM request to valid/ready bus bridge with pipeline stall and fault reporting.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = DmemTimeout,
  parameter int unsigned TO_CNT_W       = DmemToCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_ce,
  input  logic             req_we,
  input  logic [3:0]       req_sel,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             stall_req,
  output logic             access_fault,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic [WIDTH-1:0] bus_addr,
  output logic             bus_we,
  output logic [3:0]       bus_sel,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_rsp_valid,
  input  logic [WIDTH-1:0] bus_rsp_rdata,
  input  logic             bus_rsp_err
);

  dmem_state_e      state_q;
  logic [WIDTH-1:0] bus_addr_q, bus_wdata_q, rsp_rdata_q;
  logic [3:0]       bus_sel_q;
  logic             bus_we_q, fault_q;
  logic             accept, busy, expire;

  assign accept = (state_q == StIdle) && req_ce && !flush;
  assign busy   = (state_q == StReq) || (state_q == StRsp);

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_cnt #(
    .MAX_CYCLES (TIMEOUT_CYCLES),
    .CNT_W      (TO_CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (busy),
    .expire (expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], TO_CNT_W[0]};
  assign expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            bus_addr_q  <= req_addr & ~WIDTH'(3);
            bus_we_q    <= req_we;
            bus_sel_q   <= req_sel;
            bus_wdata_q <= req_wdata;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // A response arriving with ready skips RSP; it wins over a same-cycle timeout.
          if (bus_req_ready && bus_rsp_valid) begin
            rsp_rdata_q <= bus_we_q ? '0 : bus_rsp_rdata;
            fault_q     <= bus_rsp_err;
            state_q     <= StDone;
          end else if (expire) begin
            rsp_rdata_q <= '0;
            fault_q     <= 1'b1;
            state_q     <= StDone;
          end else if (bus_req_ready) begin
            state_q <= StRsp;
          end
        end
        StRsp: begin
          if (bus_rsp_valid) begin
            rsp_rdata_q <= bus_we_q ? '0 : bus_rsp_rdata;
            fault_q     <= bus_rsp_err;
            state_q     <= StDone;
          end else if (expire) begin
            rsp_rdata_q <= '0;
            fault_q     <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          fault_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational in IDLE so MEM holds the request in the very cycle it is presented.
  assign stall_req     = accept || busy;
  assign bus_req_valid = (state_q == StReq);
  assign bus_addr      = bus_addr_q;
  assign bus_we        = bus_we_q;
  assign bus_sel       = bus_sel_q;
  assign bus_wdata     = bus_wdata_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign access_fault  = fault_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized self-checking bench for dmem_bridge; acts as bus slave and MEM stage.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_ce = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata;
  logic        stall_req, access_fault, bus_req_valid, bus_we;
  logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rsp_rdata = '0;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_errors = 0;
  int n_reqs   = 0;
  int exp_reqs = 0;

  always #5 clk = ~clk;

  dmem_bridge #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (8),
    .TO_CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_ce        (req_ce),
    .req_we        (req_we),
    .req_sel       (req_sel),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .rsp_rdata     (rsp_rdata),
    .stall_req     (stall_req),
    .access_fault  (access_fault),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_sel       (bus_sel),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  // Accepted bus requests, counted independently of the transaction driver.
  always @(posedge clk) begin
    if (rst_n && bus_req_valid && bus_req_ready) n_reqs <= n_reqs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // One MEM access against a slave that raises ready after rd waiting cycles and
  // responds rs cycles after acceptance (0 = together with ready).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input int rd, input int rs,
                        input logic err, input logic [31:0] rdata, input logic fl);
    int   w, k, n_stall, n_valid;
    logic acc, sent, done, bad;
    w = 0; k = 0; n_stall = 0; n_valid = 0;
    acc = 1'b0; sent = 1'b0; done = 1'b0; bad = 1'b0;
    req_ce = 1'b1; req_we = we; req_addr = addr; req_sel = sel; req_wdata = wdata;
    flush = 1'b0;
    exp_reqs++;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
      bus_rsp_rdata = $urandom;
      if (cyc > 0) flush = fl;
      if (bus_req_valid && !acc) begin
        n_valid++;
        if (bus_addr !== (addr & 32'hFFFF_FFFC) || bus_we !== we || bus_sel !== sel ||
            bus_wdata !== wdata) bad = 1'b1;
        if (w == rd) begin
          bus_req_ready = 1'b1;
          acc = 1'b1;
          if (rs == 0) begin
            sent = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_err = err; bus_rsp_rdata = rdata;
          end
        end else begin
          w++;
        end
      end else if (acc && !sent) begin
        k++;
        if (k == rs) begin
          sent = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_err = err; bus_rsp_rdata = rdata;
        end
      end
      #1;
      if (stall_req) begin
        n_stall++;
        if (access_fault) bad = 1'b1;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    check("txn_completes", 32'(done), 32'd1);
    check("stall_cycles", n_stall, rd + rs + 2);
    check("valid_cycles", n_valid, rd + 1);
    check("bus_fields_and_no_early_fault", 32'(bad), 32'd0);
    check("rsp_rdata", rsp_rdata, we ? 32'd0 : rdata);
    check("access_fault", 32'(access_fault), 32'(err));
    bus_rsp_valid = 1'b0; bus_req_ready = 1'b0;
    next_cycle();
    req_ce = 1'b0; flush = 1'b0;
    check("fault_pulse_ends", 32'(access_fault), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check("reset_stall", 32'(stall_req), 32'd0);
    check("reset_valid", 32'(bus_req_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_fault", 32'(access_fault), 32'd0);
    check("reset_addr", bus_addr, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 32'h103, 4'b1000, 32'h5A5A5A5A, 4, 1, 1'b0, 32'h0BAD0BAD, 1'b0);
    do_txn(1'b0, 32'h200, 4'hF, 32'h0, 1, 2, 1'b1, 32'h12345678, 1'b0);

    // Flush in IDLE blocks acceptance entirely.
    req_ce = 1'b1; flush = 1'b1; req_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("flush_idle_stall", 32'(stall_req), 32'd0);
      check("flush_idle_valid", 32'(bus_req_valid), 32'd0);
      next_cycle();
    end
    req_ce = 1'b0; flush = 1'b0;
    next_cycle();
    do_txn(1'b0, 32'h304, 4'hF, 32'h0, 0, 3, 1'b0, 32'hCAFEF00D, 1'b1);

    // Back-to-back load then store; DONE must not reissue.
    do_txn(1'b0, 32'h400, 4'hF, 32'h0, 0, 0, 1'b0, 32'h01020304, 1'b0);
    do_txn(1'b1, 32'h404, 4'b0011, 32'hA5A5A5A5, 0, 0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    check("request_count", n_reqs, exp_reqs);

    for (int t = 0; t < 20; t++) begin
      logic        we;
      logic [3:0]  sel;
      we  = 1'($urandom_range(0, 1));
      sel = we ? 4'($urandom_range(1, 15)) : 4'hF;
      do_txn(we, $urandom, sel, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 2) == 0));
    end
    next_cycle();
    check("request_count_random", n_reqs, exp_reqs);

    // Asynchronous reset while waiting in RSP.
    do_txn(1'b0, 32'h500, 4'hF, 32'h0, 0, 1, 1'b0, 32'h55AA55AA, 1'b0);
    req_ce = 1'b1; req_we = 1'b1; req_addr = 32'h504; req_sel = 4'hF; req_wdata = 32'h77;
    exp_reqs++;
    next_cycle();
    bus_req_ready = 1'b1;
    next_cycle();
    bus_req_ready = 1'b0;
    #1;
    check("pre_reset_in_rsp", {31'd0, stall_req}, 32'd1);
    rst_n = 1'b0; req_ce = 1'b0;
    #1;
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_valid", 32'(bus_req_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_fault", 32'(access_fault), 32'd0);
    check("rst_fields", {bus_addr[30:0], bus_we}, 32'd0);
    check("rst_wdata_sel", {bus_wdata[27:0], bus_sel}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

`ifdef DMEM_TIMEOUT_EN
    begin
      int   n_stall, n_valid;
      logic done;
      n_stall = 0; n_valid = 0; done = 1'b0;
      req_ce = 1'b1; req_we = 1'b0; req_addr = 32'h600; req_sel = 4'hF;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        if (bus_req_valid) n_valid++;
        #1;
        if (stall_req) begin
          n_stall++;
          next_cycle();
        end else begin
          done = 1'b1;
        end
      end
      check("to_done", 32'(done), 32'd1);
      check("to_stall_cycles", n_stall, 9);
      check("to_valid_cycles", n_valid, 8);
      check("to_fault", 32'(access_fault), 32'd1);
      check("to_rdata", rsp_rdata, 32'd0);
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h13572468; bus_rsp_err = 1'b0;
      next_cycle();
      req_ce = 1'b0;
      next_cycle();
      bus_rsp_valid = 1'b0;
      #1;
      check("late_rsp_stall", 32'(stall_req), 32'd0);
      check("late_rsp_fault", 32'(access_fault), 32'd0);
      check("late_rsp_rdata", rsp_rdata, 32'd0);
      next_cycle();
    end
`endif

    check("request_count_final", n_reqs, exp_reqs);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
